ro_freq_meter: RTL and testbench
================================

Name: ro_freq_meter

Overview:
- Parametrised successor to the pad-level 16:1 ring-oscillator output mux.
- Selects one of N_CH ring-oscillator outputs and synchronises it into the wb_clk_i domain.
- Counts rising edges over a programmable gate window and reports the count on-chip, so frequency is read without probing pads.
- Supports single-shot and continuous measurement, with abort and overflow saturation.
- Sits in user_project_wrapper between the oscillator macros and the IO/register interface.

Parameters:
- N_CH, 16, number of oscillator inputs.
- SEL_W, 4, channel-select width; must satisfy 2^SEL_W >= N_CH.
- GATE_W, 16, gate-length width.
- CNT_W, 24, edge-count width.
- SYNC_STAGES, 2, synchroniser flops; minimum 2.
- SETTLE_CYCLES, 8, cycles discarded after a channel (re)selection; must be >= SYNC_STAGES+1.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- ro_in  in  N_CH  raw oscillator outputs (asynchronous).
- ch_sel  in  SEL_W  channel to measure.
- gate_len  in  GATE_W  measurement window in wb_clk_i cycles.
- start  in  1  begin measurement, level-sampled.
- continuous  in  1  repeat windows back-to-back.
- abort  in  1  cancel the current operation.
- busy  out  1  high whenever not IDLE.
- ro_out  out  1  synchronised selected oscillator, last sync stage, for pad observation.
- cur_ch  out  SEL_W  latched channel under measurement.
- count  out  CNT_W  result of the last completed window.
- count_valid  out  1  one-cycle pulse when count updates.
- overflow  out  1  last completed window saturated.

Behaviour:
- Reset (async assert, sync release): state=IDLE. busy, ro_out, cur_ch, count, count_valid and overflow are all 0. Sync chain, edge register and internal counters are cleared.
- Input path:
  - ro_in[cur_ch] feeds the SYNC_STAGES chain, then the edge register.
  - edge = sync_last & ~edge_reg.
  - If cur_ch >= N_CH, the selected input is constant 0.
  - Valid range is f_ro < f_clk/2. Faster oscillators alias; this is not detected.
- States: IDLE, SETTLE, MEASURE.
- IDLE:
  - If start=1 and abort=0 at edge T: cur_ch<=ch_sel, settle counter<=SETTLE_CYCLES-1, state->SETTLE.
  - A gate_len of 0 is treated as 1.
- SETTLE:
  - Edges are ignored; the counter decrements.
  - At 0: edge counter<=0, gate counter<=max(gate_len,1)-1, state->MEASURE.
- MEASURE:
  - Each cycle, edge counter increments if edge=1, saturating at 2^CNT_W-1 with a sticky ovf flag.
  - The gate counter decrements. The cycle where it equals 0 is the last counted cycle; an edge in that cycle is included.
  - Exactly G=max(gate_len,1) cycles are sampled.
- Window end (next edge after the last counted cycle):
  - count<=final edge count, overflow<=ovf, count_valid=1 for one cycle.
  - For a start sampled at edge T, count_valid is high in the cycle following edge T+SETTLE_CYCLES+G.
  - If continuous=0: state->IDLE and busy falls in the same cycle count_valid rises.
  - If continuous=1 and ch_sel==cur_ch: reload gate_len, clear edge counter and ovf, stay in MEASURE. There is no dead cycle; the first cycle of the new window is the count_valid cycle.
  - If continuous=1 and ch_sel!=cur_ch: cur_ch<=ch_sel, state->SETTLE.
- start while busy is ignored.
- continuous dropping mid-window: the current window finishes and reports, then IDLE.
- abort:
  - From any non-IDLE state → IDLE on the next edge.
  - No count_valid; count and overflow keep their previous values.
  - abort wins over a simultaneous start.
- Window-end and abort in the same cycle: abort wins and there is no report.
- Reset mid-operation: immediate return to reset values; no partial result.
- ch_sel changes during SETTLE/MEASURE are ignored until the next window boundary.

Test Plan:
- Reset, then start with ch_sel=3, gate_len=100, continuous=0; ro_in[3] driven synchronously with a rising edge every 4 clocks → count_valid once, count=25, overflow=0. busy falls with count_valid at T+8+100+1.
- Override CNT_W=8; ro_in[0] toggles every clock, gate_len=1000 → count=255, overflow=1. The next window on an idle channel gives count=0, overflow=0.
- gate_len=0 with ro_in[5] held high → treated as G=1, count=0, count_valid at T+SETTLE_CYCLES+2.
- continuous=1 on ch 2 (edge every 5 clocks), gate_len=50 → back-to-back count=10 pulses 50 cycles apart. Switch ch_sel to 7 (edge every 10 clocks) → a SETTLE gap of 8 cycles, then count=5. Drop continuous → one more report, then busy=0.
- abort 20 cycles into MEASURE after a prior result of 25 → busy=0 next cycle, no count_valid, count stays 25. abort+start in the same IDLE cycle → stays IDLE.
- Assert wb_rst_i mid-MEASURE, asynchronously between edges → all outputs 0 immediately; a fresh start after release measures correctly.

Source files
------------

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: selects one oscillator, synchronises it into wb_clk_i
// and counts its rising edges over a programmable gate window.
module ro_freq_meter #(
  parameter int N_CH          = 16,
  parameter int SEL_W         = 4,
  parameter int GATE_W        = 16,
  parameter int CNT_W         = 24,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [N_CH-1:0]   ro_in,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  output logic              busy,
  output logic              ro_out,
  output logic [SEL_W-1:0]  cur_ch,
  output logic [CNT_W-1:0]  count,
  output logic              count_valid,
  output logic              overflow
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic [SET_W-1:0]       settle_q;
  logic [GATE_W-1:0]      gate_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_q;
  logic [SEL_W-1:0]       cur_ch_q;
  logic [CNT_W-1:0]       count_q;
  logic                   count_valid_q;
  logic                   overflow_q;

  logic                   sel_bit;
  logic                   edge_det;
  logic [CNT_W-1:0]       cnt_d;
  logic                   ovf_d;
  logic [GATE_W-1:0]      gate_init;

  // Out-of-range channel numbers select a constant 0.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cur_ch_q == SEL_W'(i)) sel_bit = ro_in[i];
    end
  end

  always_comb begin
    edge_det  = sync_q[SYNC_STAGES-1] & ~edge_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    if (edge_det) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end
    gate_init = (gate_len == '0) ? '0 : gate_len - GATE_W'(1);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      sync_q        <= '0;
      edge_q        <= 1'b0;
      settle_q      <= '0;
      gate_q        <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      cur_ch_q      <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], sel_bit};
      edge_q        <= sync_q[SYNC_STAGES-1];
      count_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            cur_ch_q <= ch_sel;
            settle_q <= SET_W'(SETTLE_CYCLES - 1);
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (settle_q == '0) begin
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            gate_q  <= gate_init;
            state_q <= MEASURE;
          end else begin
            settle_q <= settle_q - SET_W'(1);
          end
        end
        MEASURE: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (gate_q == '0) begin
            // Last counted cycle: its edge is folded into the reported count.
            count_q       <= cnt_d;
            overflow_q    <= ovf_d;
            count_valid_q <= 1'b1;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            if (!continuous) begin
              state_q <= IDLE;
            end else if (ch_sel == cur_ch_q) begin
              gate_q <= gate_init;
            end else begin
              cur_ch_q <= ch_sel;
              settle_q <= SET_W'(SETTLE_CYCLES - 1);
              state_q  <= SETTLE;
            end
          end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            gate_q <= gate_q - GATE_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign ro_out      = sync_q[SYNC_STAGES-1];
  assign cur_ch      = cur_ch_q;
  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: directed windows on synthetic oscillators, results checked
// through an expected-result queue drained by per-instance monitors.
module tb_ro_freq_meter;

  localparam int N_CH = 16;
  localparam int S    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_CH-1:0] ro_in;

  logic        start, continuous, abort;
  logic [3:0]  ch_sel, cur_ch;
  logic [15:0] gate_len;
  logic        busy, ro_out, count_valid, overflow;
  logic [23:0] count;

  logic        start2, continuous2, abort2;
  logic [3:0]  ch_sel2, cur_ch2;
  logic [15:0] gate_len2;
  logic        busy2, ro_out2, count_valid2, overflow2;
  logic [7:0]  count2;

  ro_freq_meter dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .ro_in(ro_in), .ch_sel(ch_sel), .gate_len(gate_len),
    .start(start), .continuous(continuous), .abort(abort), .busy(busy), .ro_out(ro_out),
    .cur_ch(cur_ch), .count(count), .count_valid(count_valid), .overflow(overflow)
  );

  ro_freq_meter #(.CNT_W(8)) dut8 (
    .wb_clk_i(clk), .wb_rst_i(rst), .ro_in(ro_in), .ch_sel(ch_sel2), .gate_len(gate_len2),
    .start(start2), .continuous(continuous2), .abort(abort2), .busy(busy2), .ro_out(ro_out2),
    .cur_ch(cur_ch2), .count(count2), .count_valid(count_valid2), .overflow(overflow2)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Entry layout: [57] busy after report, [56:25] cycle, [24] overflow, [23:0] count.
  logic [63:0] exp_q[$];
  logic [63:0] exp2_q[$];

  function automatic logic [63:0] mk(input bit b, input int c, input bit o, input logic [23:0] n);
    return {6'b0, b, 32'(c), o, n};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Synchronous oscillator models: period 0 means a constant level.
  initial begin
    int per[N_CH];
    bit lvl[N_CH];
    int ph;
    ph = 0;
    for (int i = 0; i < N_CH; i++) begin per[i] = 0; lvl[i] = 1'b0; end
    per[0] = 2; per[2] = 5; per[3] = 4; per[7] = 10; lvl[5] = 1'b1;
    ro_in = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_CH; i++)
        ro_in[i] = (per[i] == 0) ? lvl[i] : ((ph % per[i]) < (per[i] / 2));
      ph++;
    end
  end

  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    if (!rst && count_valid) begin
      if (exp_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_valid dut actual count=%0d required no report (cyc %0d)", count, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("dut_count", 64'(count), 64'(e[23:0]));
        chk("dut_overflow", 64'(overflow), 64'(e[24]));
        chk("dut_report_cycle", 64'(cyc), 64'(e[56:25]));
        chk("dut_busy_at_report", 64'(busy), 64'(e[57]));
      end
    end
  end

  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    if (!rst && count_valid2) begin
      if (exp2_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_valid dut8 actual count=%0d required no report (cyc %0d)", count2, cyc);
      end else begin
        e = exp2_q.pop_front();
        chk("dut8_count", 64'(count2), 64'(e[23:0]));
        chk("dut8_overflow", 64'(overflow2), 64'(e[24]));
        chk("dut8_report_cycle", 64'(cyc), 64'(e[56:25]));
        chk("dut8_busy_at_report", 64'(busy2), 64'(e[57]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic start1(input logic [3:0] ch, input logic [15:0] g, input logic c, output int t);
    ch_sel = ch; gate_len = g; continuous = c; start = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic start8(input logic [3:0] ch, input logic [15:0] g, output int t);
    ch_sel2 = ch; gate_len2 = g; start2 = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic wait_idle(input bit which, input int max);
    int n;
    n = 0;
    while ((which ? busy2 : busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(which ? "dut8_idle_timeout" : "dut_idle_timeout", 64'(which ? busy2 : busy), 64'(0));
  endtask

  initial begin
    int t;
    start = 0; continuous = 0; abort = 0; ch_sel = 0; gate_len = 0;
    start2 = 0; continuous2 = 0; abort2 = 0; ch_sel2 = 0; gate_len2 = 0;
    repeat (3) @(negedge clk);

    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_ro_out", 64'(ro_out), 64'(0));
    chk("reset_cur_ch", 64'(cur_ch), 64'(0));
    chk("reset_count", 64'(count), 64'(0));
    chk("reset_count_valid", 64'(count_valid), 64'(0));
    chk("reset_overflow", 64'(overflow), 64'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single shot, ch3, edge every 4 clocks over 100 cycles.
    start1(4'd3, 16'd100, 1'b0, t);
    exp_q.push_back(mk(1'b0, t + S + 100, 1'b0, 24'd25));
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_cur_ch", 64'(cur_ch), 64'(3));
    wait_idle(1'b0, 200);

    // Abort 20 cycles into MEASURE keeps the previous result.
    start1(4'd3, 16'd100, 1'b0, t);
    wait_cyc(t + S + 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_count_kept", 64'(count), 64'(25));
    chk("abort_overflow_kept", 64'(overflow), 64'(0));
    wait_cyc(t + S + 110);
    chk("abort_stays_idle", 64'(busy), 64'(0));

    // Abort and start together in IDLE.
    ch_sel = 4'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 64'(busy), 64'(0));
    chk("abort_start_cur_ch", 64'(cur_ch), 64'(3));

    // gate_len 0 behaves as a one-cycle window; ch5 is constant high.
    start1(4'd5, 16'd0, 1'b0, t);
    exp_q.push_back(mk(1'b0, t + S + 1, 1'b0, 24'd0));
    wait_idle(1'b0, 50);

    // Continuous on ch2, switch to ch7, then drop continuous.
    start1(4'd2, 16'd50, 1'b1, t);
    exp_q.push_back(mk(1'b1, t + 58,  1'b0, 24'd10));
    exp_q.push_back(mk(1'b1, t + 108, 1'b0, 24'd10));
    exp_q.push_back(mk(1'b1, t + 158, 1'b0, 24'd10));
    exp_q.push_back(mk(1'b1, t + 216, 1'b0, 24'd5));
    exp_q.push_back(mk(1'b0, t + 266, 1'b0, 24'd5));
    wait_cyc(t + 110);
    ch_sel = 4'd7;
    wait_cyc(t + 120);
    chk("cont_ch_sel_ignored_mid_window", 64'(cur_ch), 64'(2));
    wait_cyc(t + 159);
    chk("cont_switch_cur_ch", 64'(cur_ch), 64'(7));
    chk("cont_switch_busy", 64'(busy), 64'(1));
    wait_cyc(t + 220);
    continuous = 1'b0;
    wait_idle(1'b0, 200);

    // Asynchronous reset in the middle of a window.
    start1(4'd3, 16'd100, 1'b0, t);
    wait_cyc(t + S + 40);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_ro_out", 64'(ro_out), 64'(0));
    chk("midrst_cur_ch", 64'(cur_ch), 64'(0));
    chk("midrst_count", 64'(count), 64'(0));
    chk("midrst_count_valid", 64'(count_valid), 64'(0));
    chk("midrst_overflow", 64'(overflow), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start1(4'd3, 16'd100, 1'b0, t);
    exp_q.push_back(mk(1'b0, t + S + 100, 1'b0, 24'd25));
    wait_idle(1'b0, 200);

    // 8-bit counter instance: saturation, then a clean window on a quiet channel.
    start8(4'd0, 16'd1000, t);
    exp2_q.push_back(mk(1'b0, t + S + 1000, 1'b1, 24'd255));
    wait_idle(1'b1, 1100);
    start8(4'd9, 16'd20, t);
    exp2_q.push_back(mk(1'b0, t + S + 20, 1'b0, 24'd0));
    wait_idle(1'b1, 100);

    repeat (5) @(negedge clk);
    chk("dut_queue_drained", 64'(exp_q.size()), 64'(0));
    chk("dut8_queue_drained", 64'(exp2_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
